// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter sharing the single-port command RAM between requesters A and B.
// Each request becomes an address command and a data command on ram_din, with read data returned per requester.
module ram_cmd_arbiter #(
   parameter int ADDR_SIZE  = 8,
   parameter int RD_TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [ADDR_SIZE-1:0] a_addr,
   input  logic [7:0]           a_wdata,
   output logic                 a_ack,
   output logic [7:0]           a_rdata,
   output logic                 a_err,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [ADDR_SIZE-1:0] b_addr,
   input  logic [7:0]           b_wdata,
   output logic                 b_ack,
   output logic [7:0]           b_rdata,
   output logic                 b_err,
   output logic [9:0]           ram_din,
   output logic                 ram_rx_valid,
   input  logic [7:0]           ram_dout,
   input  logic                 ram_tx_valid,
   output logic                 busy
);
   // state    | meaning
   // IDLE     | sample requests, grant round-robin
   // ADDR_CMD | address command on ram_din with rx_valid
   // ADDR_GAP | mandatory idle cycle between commands
   // DATA_CMD | write-data or read-data command
   // RD_WAIT  | wait for tx_valid or timeout
   // DONE     | ack pulse to the winner, flip priority
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR_CMD = 3'd1;
   localparam logic [2:0] S_ADDR_GAP = 3'd2;
   localparam logic [2:0] S_DATA_CMD = 3'd3;
   localparam logic [2:0] S_RD_WAIT  = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

   logic [2:0]       state;
   logic             prio_b;
   logic             win_b;
   logic             lat_we;
   logic [7:0]       lat_addr;
   logic [7:0]       lat_wdata;
   logic [CNT_W-1:0] rd_cnt;

   logic             grant_b;
   logic             sel_we;
   logic [7:0]       sel_addr;
   logic [7:0]       sel_wdata;

   // B wins only when A is absent or B holds the priority pointer
   always_comb begin
      grant_b   = b_req && (!a_req || prio_b);
      sel_we    = grant_b ? b_we : a_we;
      sel_addr  = grant_b ? 8'(b_addr) : 8'(a_addr);
      sel_wdata = grant_b ? b_wdata : a_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         prio_b       <= 1'b0;
         win_b        <= 1'b0;
         lat_we       <= 1'b0;
         lat_addr     <= 8'h00;
         lat_wdata    <= 8'h00;
         rd_cnt       <= '0;
         ram_din      <= 10'h000;
         ram_rx_valid <= 1'b0;
         busy         <= 1'b0;
         a_ack        <= 1'b0;
         a_rdata      <= 8'h00;
         a_err        <= 1'b0;
         b_ack        <= 1'b0;
         b_rdata      <= 8'h00;
         b_err        <= 1'b0;
      end else begin
         ram_rx_valid <= 1'b0;
         a_ack        <= 1'b0;
         b_ack        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (a_req || b_req) begin
                  win_b        <= grant_b;
                  lat_we       <= sel_we;
                  lat_addr     <= sel_addr;
                  lat_wdata    <= sel_wdata;
                  ram_din      <= {(sel_we ? 2'b00 : 2'b10), sel_addr};
                  ram_rx_valid <= 1'b1;
                  busy         <= 1'b1;
                  state        <= S_ADDR_CMD;
               end
            end
            S_ADDR_CMD: state <= S_ADDR_GAP;
            S_ADDR_GAP: begin
               ram_din      <= {(lat_we ? 2'b01 : 2'b11), (lat_we ? lat_wdata : 8'h00)};
               ram_rx_valid <= 1'b1;
               state        <= S_DATA_CMD;
            end
            S_DATA_CMD: begin
               rd_cnt <= '0;
               if (lat_we) begin
                  if (win_b) begin
                     b_ack <= 1'b1;
                     b_err <= 1'b0;
                  end else begin
                     a_ack <= 1'b1;
                     a_err <= 1'b0;
                  end
                  state <= S_DONE;
               end else begin
                  state <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               rd_cnt <= rd_cnt + CNT_W'(1);
               if (ram_tx_valid) begin
                  if (win_b) begin
                     b_ack   <= 1'b1;
                     b_err   <= 1'b0;
                     b_rdata <= ram_dout;
                  end else begin
                     a_ack   <= 1'b1;
                     a_err   <= 1'b0;
                     a_rdata <= ram_dout;
                  end
                  state <= S_DONE;
               end else if (rd_cnt == CNT_LAST) begin
                  if (win_b) begin
                     b_ack <= 1'b1;
                     b_err <= 1'b1;
                  end else begin
                     a_ack <= 1'b1;
                     a_err <= 1'b1;
                  end
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               prio_b <= ~win_b;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Scoreboard bench for ram_cmd_arbiter: a RAM model answers read-data commands,
// monitors compare issued commands and acks against queued expectations.
module tb_ram_cmd_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [7:0] a_addr = 8'h00, a_wdata = 8'h00, b_addr = 8'h00, b_wdata = 8'h00;
   logic       a_ack, a_err, b_ack, b_err, ram_rx_valid, busy;
   logic [7:0] a_rdata, b_rdata;
   logic [9:0] ram_din;
   logic [7:0] ram_dout = 8'h00;
   logic       ram_tx_valid = 1'b0;

   ram_cmd_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
      .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
      .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM model: dout/tx_valid registered on the read-data command
   logic [7:0] mem [256];
   logic [7:0] wa = 8'h00, ra = 8'h00;
   logic       ram_mute = 1'b0;
   always @(posedge clk) begin
      ram_tx_valid <= 1'b0;
      if (ram_rx_valid) begin
         case (ram_din[9:8])
            2'b00: wa <= ram_din[7:0];
            2'b01: mem[wa] <= ram_din[7:0];
            2'b10: ra <= ram_din[7:0];
            default: if (!ram_mute) begin
               ram_dout     <= mem[ra];
               ram_tx_valid <= 1'b1;
            end
         endcase
      end
   end

   typedef struct {
      logic       id;
      logic [7:0] rdata;
      logic       err;
   } exp_t;
   exp_t       ack_q[$];
   logic [9:0] cmd_q[$];
   int         total = 0;
   int         bad = 0;
   logic       chk_en = 1'b0;
   logic       prev_rx = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [9:0] c;
      if (chk_en) begin
         if (ram_rx_valid) begin
            if (cmd_q.size() == 0) begin
               total++; bad++;
               $display("FAIL cmd_unexpected: got %0h expected none", ram_din);
            end else begin
               c = cmd_q.pop_front();
               chk("ram_din", 32'(ram_din), 32'(c));
            end
            chk("cmd_gap", 32'(prev_rx), 32'd0);
         end
         if (a_ack && b_ack) begin
            total++; bad++;
            $display("FAIL dual_ack: got a=1 b=1 expected one");
         end else if (a_ack || b_ack) begin
            if (ack_q.size() == 0) begin
               total++; bad++;
               $display("FAIL ack_unexpected: got a=%0b b=%0b expected none", a_ack, b_ack);
            end else begin
               e = ack_q.pop_front();
               chk("ack_id", 32'(b_ack), 32'(e.id));
               chk("rdata", 32'(b_ack ? b_rdata : a_rdata), 32'(e.rdata));
               chk("err", 32'(b_ack ? b_err : a_err), 32'(e.err));
            end
         end
      end
      prev_rx = ram_rx_valid;
   end

   // one transaction; checks ack latency counted from the sampling IDLE cycle
   task automatic do_txn(input logic id, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input int exp_lat);
      int n;
      logic got;
      @(negedge clk);
      if (id) begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
      else    begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         got = id ? b_ack : a_ack;
      end
      a_req = 1'b0;
      b_req = 1'b0;
      chk(id ? "b_latency" : "a_latency", 32'(n), 32'(exp_lat));
   endtask

   initial begin
      int   n;
      int   acnt, bcnt;
      exp_t e;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // reset values
      #12;
      chk("rst_ram_din", 32'(ram_din), 32'd0);
      chk("rst_rx_valid", 32'(ram_rx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
      chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // reset asserted while the data command is on the bus
      @(negedge clk);
      a_we = 1'b1; a_addr = 8'h40; a_wdata = 8'h77; a_req = 1'b1;
      n = 0;
      while (!(ram_rx_valid && ram_din[9:8] == 2'b01) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_data_cmd", 32'(n), 32'd3);
      rst_n = 1'b0;
      a_req = 1'b0;
      #1;
      chk("midrst_rx_valid", 32'(ram_rx_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ack", 32'({a_ack, b_ack}), 32'd0);
      chk("midrst_din", 32'(ram_din), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_idle", 32'(busy), 32'd0);
      chk_en = 1'b1;

      // A write 0x12 <- 0xA5
      cmd_q.push_back(10'h012); cmd_q.push_back(10'h1A5);
      e.id = 1'b0; e.rdata = 8'h00; e.err = 1'b0; ack_q.push_back(e);
      do_txn(1'b0, 1'b1, 8'h12, 8'hA5, 4);

      // A read 0x12
      cmd_q.push_back(10'h212); cmd_q.push_back(10'h300);
      e.id = 1'b0; e.rdata = 8'hA5; e.err = 1'b0; ack_q.push_back(e);
      do_txn(1'b0, 1'b0, 8'h12, 8'h00, 5);

      // both requesting from reset: A write, B read, alternating
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cmd_q.push_back(10'h034); cmd_q.push_back(10'h15C);
         e.id = 1'b0; e.rdata = 8'h00; e.err = 1'b0; ack_q.push_back(e);
         cmd_q.push_back(10'h212); cmd_q.push_back(10'h300);
         e.id = 1'b1; e.rdata = 8'hA5; e.err = 1'b0; ack_q.push_back(e);
      end
      a_we = 1'b1; a_addr = 8'h34; a_wdata = 8'h5C;
      b_we = 1'b0; b_addr = 8'h12; b_wdata = 8'hEE;
      a_req = 1'b1; b_req = 1'b1;
      acnt = 0; bcnt = 0; n = 0;
      while (acnt + bcnt < 4 && n < 200) begin
         @(negedge clk);
         n++;
         if (a_ack) acnt++;
         if (b_ack) bcnt++;
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("rr_a_acks", 32'(acnt), 32'd2);
      chk("rr_b_acks", 32'(bcnt), 32'd2);
      chk("rr_mem_34", 32'(mem[8'h34]), 32'h5C);

      // B read with a silent RAM times out, rdata kept
      ram_mute = 1'b1;
      cmd_q.push_back(10'h256); cmd_q.push_back(10'h300);
      e.id = 1'b1; e.rdata = 8'hA5; e.err = 1'b1; ack_q.push_back(e);
      do_txn(1'b1, 1'b0, 8'h56, 8'h00, 12);
      ram_mute = 1'b0;

      // B write after timeout clears err
      cmd_q.push_back(10'h0FF); cmd_q.push_back(10'h13C);
      e.id = 1'b1; e.rdata = 8'hA5; e.err = 1'b0; ack_q.push_back(e);
      do_txn(1'b1, 1'b1, 8'hFF, 8'h3C, 4);

      repeat (4) @(negedge clk);
      chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
      chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
      chk("end_idle", 32'(busy), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
